// File: rtl/reg_bypass_scoreboard.sv
// ID-stage operand bypass: per-port forwarding from youngest-first pipeline stages,
// same-cycle completion bypass, long-latency busy scoreboard and a stall watchdog.

module reg_bypass_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_FWD    = 2
) (
  input  logic                                en_i,
  input  logic [ADDR_WIDTH-1:0]               addr_i,
  input  logic [DATA_WIDTH-1:0]               rdata_i,
  input  logic [NUM_FWD-1:0]                  fwd_we_i,
  input  logic [NUM_FWD-1:0][ADDR_WIDTH-1:0]  fwd_addr_i,
  input  logic [NUM_FWD-1:0]                  fwd_valid_i,
  input  logic [NUM_FWD-1:0][DATA_WIDTH-1:0]  fwd_data_i,
  input  logic                                cmp_valid_i,
  input  logic [ADDR_WIDTH-1:0]               cmp_addr_i,
  input  logic [DATA_WIDTH-1:0]               cmp_data_i,
  input  logic                                busy_i,
  output logic [DATA_WIDTH-1:0]               data_o,
  output logic                                hazard_o
);
  logic hit;

  always_comb begin
    data_o   = '0;
    hazard_o = 1'b0;
    hit      = 1'b0;
    if (en_i && addr_i != '0) begin
      // addr_i is nonzero here, so a stage targeting r0 can never match
      for (int j = 0; j < NUM_FWD; j++) begin
        if (!hit && fwd_we_i[j] && fwd_addr_i[j] == addr_i) begin
          hit = 1'b1;
          if (fwd_valid_i[j]) data_o = fwd_data_i[j];
          else                hazard_o = 1'b1;
        end
      end
      if (!hit) begin
        if (cmp_valid_i && cmp_addr_i == addr_i) data_o = cmp_data_i;
        else if (busy_i)                          hazard_o = 1'b1;
        else                                      data_o = rdata_i;
      end
    end
  end
endmodule

module reg_bypass_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_FWD    = 2,
  parameter int MAX_STALL  = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ-1:0]            read_en,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
  input  logic [NUM_READ*DATA_WIDTH-1:0] reg_data,
  input  logic [NUM_FWD-1:0]             fwd_we,
  input  logic [NUM_FWD*ADDR_WIDTH-1:0]  fwd_addr,
  input  logic [NUM_FWD-1:0]             fwd_valid,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]  fwd_data,
  input  logic                           issue_valid,
  input  logic [ADDR_WIDTH-1:0]          issue_addr,
  input  logic                           complete_valid,
  input  logic [ADDR_WIDTH-1:0]          complete_addr,
  input  logic [DATA_WIDTH-1:0]          complete_data,
  input  logic                           flush,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  output logic                           stall,
  output logic [2**ADDR_WIDTH-1:0]       busy,
  output logic [7:0]                     stall_count,
  output logic                           timeout
);
  localparam int NREG = 2**ADDR_WIDTH;

  logic [NUM_READ-1:0] hazard;
  logic [NREG-1:0]     busy_q, busy_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                to_q, to_d;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_port
    reg_bypass_port #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_FWD(NUM_FWD)
    ) u_port (
      .en_i        (read_en[i]),
      .addr_i      (read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .rdata_i     (reg_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .fwd_we_i    (fwd_we),
      .fwd_addr_i  (fwd_addr),
      .fwd_valid_i (fwd_valid),
      .fwd_data_i  (fwd_data),
      .cmp_valid_i (complete_valid),
      .cmp_addr_i  (complete_addr),
      .cmp_data_i  (complete_data),
      .busy_i      (busy_q[read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]]),
      .data_o      (read_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .hazard_o    (hazard[i])
    );
  end

  assign stall = (|hazard) & ~flush;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      // clear before set so an issue colliding with a completion stays busy
      if (complete_valid) busy_d[complete_addr] = 1'b0;
      if (issue_valid)    busy_d[issue_addr]    = 1'b1;
      busy_d[0] = 1'b0;
    end
  end

  always_comb begin
    cnt_d = '0;
    to_d  = to_q;
    if (stall) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      if (cnt_q == 8'(MAX_STALL - 1)) to_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      to_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      to_q   <= to_d;
    end
  end

  assign busy        = busy_q;
  assign stall_count = cnt_q;
  assign timeout     = to_q;
endmodule

// File: tb/tb_reg_bypass_scoreboard.sv
// Directed bench for reg_bypass_scoreboard (default parameters), hand-computed expectations.

module tb_reg_bypass_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  read_en;
  logic [9:0]  read_addr;
  logic [63:0] reg_data;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_addr;
  logic [1:0]  fwd_valid;
  logic [63:0] fwd_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        complete_valid;
  logic [4:0]  complete_addr;
  logic [31:0] complete_data;
  logic        flush;
  logic [63:0] read_data;
  logic        stall;
  logic [31:0] busy;
  logic [7:0]  stall_count;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  reg_bypass_scoreboard dut (
    .clk(clk), .rst(rst), .read_en(read_en), .read_addr(read_addr), .reg_data(reg_data),
    .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .complete_valid(complete_valid),
    .complete_addr(complete_addr), .complete_data(complete_data), .flush(flush),
    .read_data(read_data), .stall(stall), .busy(busy), .stall_count(stall_count),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    read_en = '0; read_addr = '0; reg_data = '0;
    fwd_we = '0; fwd_addr = '0; fwd_valid = '0; fwd_data = '0;
    issue_valid = 1'b0; issue_addr = '0;
    complete_valid = 1'b0; complete_addr = '0; complete_data = '0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; idle();
    tick(); tick();
    rst = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_cnt", stall_count, 0);
    chk("rst_to", timeout, 0);

    // plain regfile read
    read_en = 2'b11; read_addr = {5'd4, 5'd3}; reg_data = {32'hB, 32'hA}; #1;
    chk("rf_read", read_data, {32'hB, 32'hA});
    chk("rf_stall", stall, 0);

    // youngest stage wins, then older stage, then r0
    read_en = 2'b01; fwd_we = 2'b11; fwd_valid = 2'b11;
    fwd_addr = {5'd3, 5'd3}; fwd_data = {32'h22, 32'h11}; #1;
    chk("fwd_s0", read_data[31:0], 32'h11);
    fwd_we = 2'b10; #1;
    chk("fwd_s1", read_data[31:0], 32'h22);
    fwd_we = 2'b01; fwd_addr = {5'd3, 5'd0}; read_addr = {5'd4, 5'd0}; #1;
    chk("fwd_r0", read_data[31:0], 32'h0);
    chk("fwd_r0_stall", stall, 0);

    // in-flight load in EX, then ready in MEM
    idle(); read_en = 2'b10; read_addr = {5'd5, 5'd0};
    fwd_we = 2'b01; fwd_valid = 2'b00; fwd_addr = {5'd0, 5'd5}; #1;
    chk("load_stall", stall, 1);
    tick();
    chk("load_cnt", stall_count, 1);
    fwd_we = 2'b10; fwd_valid = 2'b10; fwd_addr = {5'd5, 5'd0}; fwd_data = {32'h55, 32'h0}; #1;
    chk("load_fwd", read_data[63:32], 32'h55);
    chk("load_nostall", stall, 0);
    tick();
    chk("load_cnt0", stall_count, 0);

    // scoreboard hazard and completion bypass
    idle(); issue_valid = 1'b1; issue_addr = 5'd7;
    tick();
    chk("sb_busy7", busy, 32'h80);
    issue_valid = 1'b0; read_en = 2'b01; read_addr = {5'd0, 5'd7}; #1;
    chk("sb_stall", stall, 1);
    tick(); tick(); tick();
    chk("sb_cnt3", stall_count, 3);
    complete_valid = 1'b1; complete_addr = 5'd7; complete_data = 32'h77; #1;
    chk("sb_cmp_data", read_data[31:0], 32'h77);
    chk("sb_cmp_stall", stall, 0);
    tick();
    chk("sb_clr", busy, 0);
    chk("sb_cnt0", stall_count, 0);

    // collision, r0 issue, flush
    idle(); issue_valid = 1'b1; issue_addr = 5'd9;
    complete_valid = 1'b1; complete_addr = 5'd9;
    tick();
    chk("coll_busy9", busy, 32'h200);
    complete_valid = 1'b0; issue_addr = 5'd0;
    tick();
    chk("r0_never", busy, 32'h200);
    issue_addr = 5'd2; flush = 1'b1; read_en = 2'b01; read_addr = {5'd0, 5'd9}; #1;
    chk("flush_stall", stall, 0);
    tick();
    chk("flush_busy", busy, 0);

    // watchdog and saturation
    idle(); issue_valid = 1'b1; issue_addr = 5'd12;
    tick();
    issue_valid = 1'b0; read_en = 2'b01; read_addr = {5'd0, 5'd12};
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 14) chk("to_early", timeout, 0);
      if (k == 15) begin
        chk("to_set", timeout, 1);
        chk("to_cnt15", stall_count, 15);
      end
    end
    chk("cnt_sat", stall_count, 255);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_keeps_to", timeout, 1);
    chk("flush_cnt0", stall_count, 0);
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    tick(); tick();
    chk("restall_cnt", stall_count, 2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", stall_count, 0);
    chk("mid_rst_to", timeout, 0);
    chk("mid_rst_stall", stall, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_bypass_scoreboard.md
Name: reg_bypass_scoreboard

Overview:
Parametrised register-read bypass unit for the ID stage. It serves NUM_READ read ports and forwards from NUM_FWD pipeline stages, ordered youngest first. A per-register busy scoreboard tracks long-latency writes (loads, mul/div) so that consumers stall until the result arrives, and a registered stall watchdog flags deadlock. It sits between the regfile, the ID stage and the EX/MEM/WB result buses.

Parameters:
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 5, register address width; NREG = 2**ADDR_WIDTH
NUM_READ, 2, number of read ports
NUM_FWD, 2, number of forwarding stages; index 0 is youngest (EX)
MAX_STALL, 15, consecutive stall cycles that trigger timeout; must be >=1 and < 2**8

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-low reset
read_en  in  NUM_READ  per-port read enable
read_addr  in  NUM_READ*ADDR_WIDTH  per-port address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
reg_data  in  NUM_READ*DATA_WIDTH  regfile read data, packed the same way
fwd_we  in  NUM_FWD  stage j writes a register
fwd_addr  in  NUM_FWD*ADDR_WIDTH  stage j destination
fwd_valid  in  NUM_FWD  stage j data is ready (0 = load still in flight)
fwd_data  in  NUM_FWD*DATA_WIDTH  stage j result
issue_valid  in  1  long-latency op issued this cycle
issue_addr  in  ADDR_WIDTH  its destination
complete_valid  in  1  long-latency result returns this cycle
complete_addr  in  ADDR_WIDTH  its destination
complete_data  in  DATA_WIDTH  its result
flush  in  1  pipeline flush; cancels all pending long-latency ops
read_data  out  NUM_READ*DATA_WIDTH  bypassed operands (combinational)
stall  out  1  operand hazard; ID must hold (combinational)
busy  out  2**ADDR_WIDTH  registered scoreboard bits
stall_count  out  8  registered count of consecutive stall cycles
timeout  out  1  sticky watchdog flag (registered)

Behaviour:
- Per port i, combinational, priority top-down:
  - read_en[i]=0 or read_addr=0 -> data 0, no hazard.
  - Lowest j with fwd_we[j] and fwd_addr[j]==addr: if fwd_valid[j], data = fwd_data[j]; else hazard. Older stages are ignored once a younger stage matches.
  - Else if complete_valid and complete_addr==addr -> complete_data, no hazard. Same-cycle completion bypass.
  - Else if busy[addr] -> hazard.
  - Else -> reg_data[i].
  - Stages with fwd_addr=0 never match.
- On a hazard, read_data for that port is don't-care; the bench checks it only when stall=0.
- stall = OR of port hazards, forced to 0 when flush=1.
- Scoreboard, registered; applied next edge in this priority:
  - rst=0 -> all busy bits 0.
  - flush=1 -> all busy bits 0; issue and complete that cycle are ignored.
  - Otherwise clear busy[complete_addr] if complete_valid, then set busy[issue_addr] if issue_valid. Set wins on an address collision.
  - Address 0 is never set; busy[0] is always 0.
  - Completion to a non-busy register is harmless: it stays 0.
- stall_count:
  - Reset 0.
  - Each edge: stall=1 -> increment, saturating at 255; stall=0 -> 0.
- timeout:
  - Reset 0.
  - Set on the edge where stall=1 and stall_count==MAX_STALL-1, so it is high MAX_STALL cycles after stall first asserts.
  - Cleared only by reset; flush does not clear it.
- Reset mid-stall: stall_count, busy and timeout are all 0 after the edge. stall may still be asserted combinationally by fwd hazards.
- Latency: read_data and stall 0 cycles; busy, stall_count and timeout 1 cycle.

Test Plan:
- Reset, then read_en=2'b11, addrs 3/4, reg_data 0xA/0xB, no fwd -> read_data {0xB,0xA}, stall=0, busy=0, stall_count=0, timeout=0.
- fwd stage0 we/valid addr3 data 0x11 and stage1 addr3 data 0x22; port0 reads r3 -> 0x11. Drop stage0 -> 0x22. Read r0 with stage0 addr0 -> 0.
- Stage0 addr5 fwd_valid=0 (load); port1 reads r5 -> stall=1. Next cycle the load is in stage1 with valid=1 and stage0 empty -> read_data port1 = stage1 data, stall=0.
- issue r7; next cycle busy[7]=1; read r7 -> stall. Hold 3 cycles -> stall_count=3. complete_valid r7 data 0x77 -> read_data 0x77, stall=0 that cycle; busy[7]=0 and stall_count=0 next cycle.
- Same cycle issue r9 and complete r9 -> busy[9]=1 after the edge. Issue r0 -> busy[0] stays 0. Issue r2 with flush=1 -> busy all 0, stall=0.
- Hold a busy-register hazard for MAX_STALL=15 cycles -> timeout rises on the 15th edge. Keep stalling to 300 cycles -> stall_count saturates at 255. Assert rst=0 for one edge -> all outputs return to 0.
